// File: rtl/unidade_controle_pkg.sv
// rtl/unidade_controle_pkg.sv - shared types and codes for the multicycle control unit
package unidade_controle_pkg;

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECOD       = 4'd1,
        EXEC_ULA    = 4'd2,
        ESCREVE_ULA = 4'd3,
        CALC_END    = 4'd4,
        ACESSO_LER  = 4'd5,
        ESCREVE_MEM = 4'd6,
        ACESSO_ESC  = 4'd7,
        DESVIO      = 4'd8,
        SALTO       = 4'd9,
        PARADO      = 4'd10,
        ERRO        = 4'd11
    } estado_t;

    localparam logic [2:0] OP_ULA_R  = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_BEQZ   = 3'b011;
    localparam logic [2:0] OP_ULA_I  = 3'b100;
    localparam logic [2:0] OP_JUMP   = 3'b101;
    localparam logic [2:0] OP_ULA_R2 = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b111;

    localparam logic [1:0] ULA_ADD  = 2'b00;
    localparam logic [1:0] ULA_SUB  = 2'b01;
    localparam logic [1:0] ULA_FUNC = 2'b10;
    localparam logic [1:0] ULA_IMM  = 2'b11;

    localparam logic [1:0] FONTE_REG = 2'b00;
    localparam logic [1:0] FONTE_IMM = 2'b01;
    localparam logic [1:0] FONTE_UM  = 2'b10;

    // An instruction retires when it hands control back to fetch, or when it halts.
    function automatic logic retira(input estado_t de, input estado_t para);
        logic fim;
        fim = (de == ESCREVE_ULA) || (de == ESCREVE_MEM) || (de == ACESSO_ESC) ||
              (de == DESVIO) || (de == SALTO);
        return ((para == BUSCA) && fim) || ((para == PARADO) && (de != PARADO));
    endfunction

endpackage

// File: rtl/contador_espera.sv
// rtl/contador_espera.sv - consecutive memory-wait counter with timeout compare
module contador_espera #(
    parameter int ESPERA_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ativo,
    input  logic pronta,
    input  logic limpa,
    output logic estouro
);

    localparam int CW = (ESPERA_MAX > 0) ? $clog2(ESPERA_MAX + 1) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(ESPERA_MAX);

    logic [CW-1:0] cont;

    // A zero limit disables the timeout entirely; ready in the limit cycle still wins.
    assign estouro = (ESPERA_MAX != 0) && ativo && !pronta && (cont == LIMITE);

    // Count stalled cycles of one access, saturating at the limit, restarting on any completion or state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont <= '0;
        end else if (!ativo || pronta || limpa) begin
            cont <= '0;
        end else if (cont != LIMITE) begin
            cont <= cont + CW'(1);
        end
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - multicycle control unit FSM with memory handshake and timeout
module unidade_controle_multiciclo
    import unidade_controle_pkg::*;
#(
    parameter int OPCODE_W   = 3,
    parameter int ESPERA_MAX = 15,
    parameter int CONT_W     = 16
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemPronta,
    output logic [1:0]          ULAOp,
    output logic [1:0]          ULAFonte,
    output logic                Beqz,
    output logic                RegFonte,
    output logic                EscMem,
    output logic                LerMem,
    output logic                SelDest,
    output logic                Ji,
    output logic                EscReg,
    output logic                EscPC,
    output logic                EscIR,
    output logic                IouD,
    output logic                Erro,
    output logic [3:0]          Estado,
    output logic [CONT_W-1:0]   Retiradas
);

    estado_t estado;
    estado_t proximo;
    logic [2:0] op_dec;
    logic [2:0] op_reg;
    logic [OPCODE_W+2:0] op_ext;
    logic em_espera;
    logic estouro;

    // Opcodes wider than the map fold every out-of-range value onto halt.
    assign op_ext = {3'b000, Opcode};
    assign op_dec = (op_ext[OPCODE_W+2:3] != '0) ? OP_HALT : op_ext[2:0];

    assign em_espera = (estado == BUSCA) || (estado == ACESSO_LER) || (estado == ACESSO_ESC);
    assign Estado    = estado;

    contador_espera #(
        .ESPERA_MAX(ESPERA_MAX)
    ) u_espera (
        .clk    (Clock),
        .rst_n  (Resetn),
        .ativo  (em_espera),
        .pronta (MemPronta),
        .limpa  (proximo != estado),
        .estouro(estouro)
    );

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            estado <= BUSCA;
        end else begin
            estado <= proximo;
        end
    end

    // Capture the decoded opcode in DECOD so later states ignore the instruction register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            op_reg <= OP_ULA_R;
        end else if (estado == DECOD) begin
            op_reg <= op_dec;
        end
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Retiradas <= '0;
        end else if (retira(estado, proximo)) begin
            Retiradas <= Retiradas + CONT_W'(1);
        end
    end

    // Next-state logic; DECOD branches on the live opcode, later states on the latched copy.
    always_comb begin
        proximo = estado;
        case (estado)
            BUSCA: begin
                if (MemPronta)    proximo = DECOD;
                else if (estouro) proximo = ERRO;
            end
            DECOD: begin
                case (op_dec)
                    OP_ULA_R, OP_ULA_I, OP_ULA_R2: proximo = EXEC_ULA;
                    OP_LOAD, OP_STORE:             proximo = CALC_END;
                    OP_BEQZ:                       proximo = DESVIO;
                    OP_JUMP:                       proximo = SALTO;
                    default:                       proximo = PARADO;
                endcase
            end
            EXEC_ULA:    proximo = ESCREVE_ULA;
            ESCREVE_ULA: proximo = BUSCA;
            CALC_END:    proximo = (op_reg == OP_STORE) ? ACESSO_ESC : ACESSO_LER;
            ACESSO_LER: begin
                if (MemPronta)    proximo = ESCREVE_MEM;
                else if (estouro) proximo = ERRO;
            end
            ESCREVE_MEM: proximo = BUSCA;
            ACESSO_ESC: begin
                if (MemPronta)    proximo = BUSCA;
                else if (estouro) proximo = ERRO;
            end
            DESVIO:  proximo = BUSCA;
            SALTO:   proximo = BUSCA;
            PARADO:  proximo = PARADO;
            ERRO:    proximo = ERRO;
            default: proximo = BUSCA;
        endcase
    end

    // Output decode; reset gates everything so no enable survives the asynchronous edge.
    always_comb begin
        ULAOp    = ULA_ADD;
        ULAFonte = FONTE_REG;
        Beqz     = 1'b0;
        RegFonte = 1'b0;
        EscMem   = 1'b0;
        LerMem   = 1'b0;
        SelDest  = 1'b0;
        Ji       = 1'b0;
        EscReg   = 1'b0;
        EscPC    = 1'b0;
        EscIR    = 1'b0;
        IouD     = 1'b0;
        Erro     = 1'b0;
        if (Resetn) begin
            case (estado)
                BUSCA: begin
                    LerMem   = 1'b1;
                    ULAFonte = FONTE_UM;
                    EscIR    = MemPronta;
                    EscPC    = MemPronta;
                end
                EXEC_ULA: begin
                    case (op_reg)
                        OP_ULA_I: begin
                            ULAOp    = ULA_IMM;
                            ULAFonte = FONTE_IMM;
                        end
                        OP_ULA_R2: ULAOp = ULA_SUB;
                        default:   ULAOp = ULA_FUNC;
                    endcase
                end
                ESCREVE_ULA: EscReg = 1'b1;
                CALC_END:    ULAFonte = FONTE_IMM;
                ACESSO_LER: begin
                    LerMem = 1'b1;
                    IouD   = 1'b1;
                end
                ESCREVE_MEM: begin
                    EscReg   = 1'b1;
                    RegFonte = 1'b1;
                end
                ACESSO_ESC: begin
                    EscMem  = 1'b1;
                    IouD    = 1'b1;
                    SelDest = 1'b1;
                end
                DESVIO: begin
                    Beqz  = 1'b1;
                    ULAOp = ULA_SUB;
                end
                SALTO: begin
                    Ji    = 1'b1;
                    EscPC = 1'b1;
                end
                ERRO:    Erro = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb/tb_unidade_controle_multiciclo.sv - self-checking bench for the multicycle control unit
module tb_unidade_controle_multiciclo;
    import unidade_controle_pkg::*;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [2:0]  Opcode;
    logic        MemPronta;
    logic [1:0]  ULAOp, ULAFonte;
    logic        Beqz, RegFonte, EscMem, LerMem, SelDest, Ji, EscReg, EscPC, EscIR, IouD, Erro;
    logic [3:0]  Estado;
    logic [15:0] Retiradas;

    unidade_controle_multiciclo #(
        .OPCODE_W(3), .ESPERA_MAX(15), .CONT_W(16)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Opcode(Opcode), .MemPronta(MemPronta),
        .ULAOp(ULAOp), .ULAFonte(ULAFonte), .Beqz(Beqz), .RegFonte(RegFonte),
        .EscMem(EscMem), .LerMem(LerMem), .SelDest(SelDest), .Ji(Ji),
        .EscReg(EscReg), .EscPC(EscPC), .EscIR(EscIR), .IouD(IouD), .Erro(Erro),
        .Estado(Estado), .Retiradas(Retiradas)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [1:0] ula_op;
        logic [1:0] ula_fonte;
        logic beqz, reg_fonte, esc_mem, ler_mem, sel_dest, ji, esc_reg, esc_pc, esc_ir, iou_d, erro;
    } ctrl_t;

    typedef struct {
        estado_t    est;
        logic       mem;
        logic [2:0] op;
        ctrl_t      c;
        int         ret;
    } passo_t;

    passo_t fila[$];
    int checks = 0;
    int failures = 0;
    int ret_model = 0;

    function automatic ctrl_t obs_ctrl();
        return {ULAOp, ULAFonte, Beqz, RegFonte, EscMem, LerMem, SelDest, Ji, EscReg, EscPC, EscIR, IouD, Erro};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poe(input estado_t est, input logic mem, input logic [2:0] op, input ctrl_t c);
        fila.push_back('{est, mem, op, c, ret_model});
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic add_erro();
        ctrl_t c;
        c = '0;
        c.erro = 1'b1;
        repeat (5) poe(ERRO, rbit(), rop(), c);
    endtask

    // One instruction as a list of cycles: wf/wm are stall cycles on fetch/access; 16 or more means timeout.
    task automatic add_instr(input logic [2:0] op, input int wf, input int wm, input int parado);
        ctrl_t c;
        estado_t acc;
        c = '0;
        c.ler_mem = 1'b1;
        c.ula_fonte = 2'b10;
        for (int i = 0; i < wf && i < 16; i++) poe(BUSCA, 1'b0, op, c);
        if (wf >= 16) begin
            add_erro();
            return;
        end
        c.esc_ir = 1'b1;
        c.esc_pc = 1'b1;
        poe(BUSCA, 1'b1, op, c);
        c = '0;
        poe(DECOD, rbit(), op, c);
        case (op)
            3'd0, 3'd4, 3'd6: begin
                c.ula_op    = (op == 3'd4) ? 2'b11 : (op == 3'd6) ? 2'b01 : 2'b10;
                c.ula_fonte = (op == 3'd4) ? 2'b01 : 2'b00;
                poe(EXEC_ULA, rbit(), rop(), c);
                c = '0;
                c.esc_reg = 1'b1;
                poe(ESCREVE_ULA, rbit(), rop(), c);
                ret_model++;
            end
            3'd1, 3'd2: begin
                c.ula_fonte = 2'b01;
                poe(CALC_END, rbit(), rop(), c);
                c = '0;
                c.iou_d = 1'b1;
                if (op == 3'd1) begin
                    c.ler_mem = 1'b1;
                    acc = ACESSO_LER;
                end else begin
                    c.esc_mem = 1'b1;
                    c.sel_dest = 1'b1;
                    acc = ACESSO_ESC;
                end
                for (int i = 0; i < wm && i < 16; i++) poe(acc, 1'b0, rop(), c);
                if (wm >= 16) begin
                    add_erro();
                    return;
                end
                poe(acc, 1'b1, rop(), c);
                if (op == 3'd1) begin
                    c = '0;
                    c.esc_reg = 1'b1;
                    c.reg_fonte = 1'b1;
                    poe(ESCREVE_MEM, rbit(), rop(), c);
                end
                ret_model++;
            end
            3'd3: begin
                c.beqz = 1'b1;
                c.ula_op = 2'b01;
                poe(DESVIO, rbit(), rop(), c);
                ret_model++;
            end
            3'd5: begin
                c.ji = 1'b1;
                c.esc_pc = 1'b1;
                poe(SALTO, rbit(), rop(), c);
                ret_model++;
            end
            default: begin
                ret_model++;
                repeat (parado) poe(PARADO, rbit(), rop(), c);
            end
        endcase
    endtask

    task automatic roda(input int n);
        passo_t e;
        int k;
        k = 0;
        while (fila.size() > 0 && (n < 0 || k < n)) begin
            e = fila.pop_front();
            Opcode = e.op;
            MemPronta = e.mem;
            @(negedge Clock);
            chk($sformatf("estado@%s", e.est.name()), 32'(Estado), 32'(e.est));
            chk($sformatf("ctrl@%s", e.est.name()), 32'(obs_ctrl()), 32'(e.c));
            chk($sformatf("retiradas@%s", e.est.name()), 32'(Retiradas), 32'(e.ret));
            @(posedge Clock);
            #1;
            k++;
        end
    endtask

    task automatic reset_check();
        Resetn = 1'b0;
        #1;
        chk("rst_ctrl", 32'(obs_ctrl()), 32'd0);
        chk("rst_estado", 32'(Estado), 32'(BUSCA));
        chk("rst_retiradas", 32'(Retiradas), 32'd0);
        @(negedge Clock);
        chk("rst_ctrl_hold", 32'(obs_ctrl()), 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        ret_model = 0;
        fila.delete();
    endtask

    initial begin
        passo_t e;
        Resetn = 1'b0;
        Opcode = 3'd0;
        MemPronta = 1'b0;
        @(posedge Clock);
        #1;
        reset_check();

        add_instr(3'd0, 0, 0, 0);
        roda(-1);
        add_instr(3'd1, 0, 3, 0);
        roda(-1);
        add_instr(3'd3, 0, 0, 0);
        add_instr(3'd5, 0, 0, 0);
        roda(-1);
        add_instr(3'd2, 15, 15, 0);
        add_instr(3'd1, 2, 15, 0);
        roda(-1);

        repeat (40) begin
            add_instr(3'($urandom_range(0, 6)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
            roda(-1);
        end

        add_instr(3'd2, 0, 6, 0);
        roda(3);
        e = fila.pop_front();
        Opcode = e.op;
        MemPronta = e.mem;
        @(negedge Clock);
        chk("escmem_antes_reset", 32'(EscMem), 32'd1);
        chk("retiradas_antes_reset", 32'(Retiradas), 32'(e.ret));
        #2;
        reset_check();
        chk("escmem_em_reset", 32'(EscMem), 32'd0);

        add_instr(3'd4, 1, 0, 0);
        roda(-1);
        add_instr(3'd0, 16, 0, 0);
        roda(-1);
        reset_check();
        add_instr(3'd1, 0, 16, 0);
        roda(-1);
        reset_check();
        add_instr(3'd2, 1, 16, 0);
        roda(-1);
        reset_check();

        add_instr(3'd7, $urandom_range(0, 2), 0, 100);
        roda(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
# unidade_controle_multiciclo

Multicycle control unit for the 3-bit-opcode processor. It replaces single-cycle decode with a registered state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It stalls on a memory-ready handshake and detects memory timeouts. It also counts retired instructions. It sits between the instruction register and the datapath muxes and enables, and drives the same control set as the single-cycle unit plus `EscIR`, `IouD`, `Erro`, `Estado` and `Retiradas`.

## Interface
- `OPCODE_W`, 3: opcode width; opcodes wider than 3 bits decode only values 0–7 and treat others as halt.
- `ESPERA_MAX`, 15: maximum consecutive wait cycles on one memory access; 0 disables the timeout.
- `CONT_W`, 16: width of the retired-instruction counter.
- `Clock` input 1: single clock, rising edge.
- `Resetn` input 1: asynchronous, active-low reset.
- `Opcode` input `OPCODE_W`: opcode field from the instruction register.
- `MemPronta` input 1: memory has completed the current read or write this cycle.
- `ULAOp` output 2, `ULAFonte` output 2, `Beqz`, `RegFonte`, `EscMem`, `LerMem`, `SelDest`, `Ji`, `EscReg`, `EscPC` output 1: datapath controls. Meanings are unchanged from the single-cycle unit.
- `EscIR` output 1: load the instruction register.
- `IouD` output 1: memory address source; 0 = PC, 1 = ALU result.
- `Erro` output 1: sticky memory-timeout flag.
- `Estado` output 4: current state code.
- `Retiradas` output `CONT_W`: number of completed instructions.

## Operation
- Opcode map: 000 ALU reg (`ULAOp` 10), 001 load, 010 store, 011 beqz, 100 ALU immediate (`ULAOp` 11, `ULAFonte` 01), 101 jump, 110 ALU reg (`ULAOp` 01), 111 halt.
- `Opcode` is latched into an internal register in DECOD; every later state decodes from that latched copy.
- Outputs not listed for a state are 0.
- States and transitions:
  - BUSCA: `LerMem`=1, `IouD`=0, `ULAFonte`=10 (constant 1), `ULAOp`=00. `EscIR` and `EscPC` equal `MemPronta` (Mealy). Go to DECOD when `MemPronta`=1, otherwise stay.
  - DECOD: no outputs asserted. Go to EXEC_ULA for 000/100/110, CALC_END for 001/010, DESVIO for 011, SALTO for 101, PARADO for 111.
  - EXEC_ULA: `ULAOp` and `ULAFonte` per the opcode map. Go to ESCREVE_ULA.
  - ESCREVE_ULA: `EscReg`=1, `RegFonte`=0. Go to BUSCA.
  - CALC_END: `ULAFonte`=01, `ULAOp`=00. Go to ACESSO_LER for a load, ACESSO_ESC for a store.
  - ACESSO_LER: `LerMem`=1, `IouD`=1. Go to ESCREVE_MEM on `MemPronta`, otherwise stay.
  - ESCREVE_MEM: `EscReg`=1, `RegFonte`=1. Go to BUSCA.
  - ACESSO_ESC: `EscMem`=1, `IouD`=1, `SelDest`=1. Go to BUSCA on `MemPronta`, otherwise stay.
  - DESVIO: `Beqz`=1, `ULAOp`=01. The datapath gates the PC write with the ALU zero flag. Go to BUSCA.
  - SALTO: `Ji`=1, `EscPC`=1. Go to BUSCA.
  - PARADO: all datapath outputs 0. Exit only through reset.
  - ERRO: all datapath outputs 0, `Erro`=1. Exit only through reset.
- Wait counter:
  - Counts consecutive cycles in BUSCA, ACESSO_LER or ACESSO_ESC with `MemPronta`=0.
  - Clears on any state change or when `MemPronta`=1.
  - When it reaches `ESPERA_MAX` with `MemPronta` still 0, the next state is ERRO.
  - `MemPronta`=1 in that same cycle wins: the access completes and no error is raised.
- `Retiradas` increments by 1 on every transition into BUSCA from ESCREVE_ULA, ESCREVE_MEM, ACESSO_ESC, DESVIO or SALTO. It also increments on entry to PARADO. It wraps modulo 2^`CONT_W`.

## Timing
- Reset is asynchronous. While `Resetn`=0:
  - State is BUSCA, the wait counter is 0, `Retiradas` is 0 and `Erro` is 0.
  - All other outputs are forced to 0.
- The first fetch starts on the first rising edge after `Resetn` deasserts.
- Minimum latency with `MemPronta` held at 1: ALU 4 cycles, load 5, store 4, beqz 3, jump 3.
- Each wait cycle adds exactly 1 cycle to these latencies.
- `Estado` is a registered value; all other outputs are combinational from state, except the Mealy terms in BUSCA.
- Resetn asserted mid-instruction aborts the instruction immediately; no enable stays asserted after the asynchronous edge.

## Structure
- `unidade_controle_pkg` holds:
  - the state enum, encoded in 4 bits;
  - opcode localparams;
  - `ULAOp` codes (00 add, 01 sub, 10 func, 11 imm);
  - `ULAFonte` codes (00 reg, 01 imm, 10 const 1).
- One sub-module, `contador_espera`, implements the parametrised wait counter and timeout compare.

## Test plan
- Opcode 000, `MemPronta`=1 constant, from reset: `Estado` sequence BUSCA, DECOD, EXEC_ULA, ESCREVE_ULA, BUSCA. `EscReg` is high for exactly 1 cycle and `Retiradas` goes 0→1.
- Opcode 001 with `MemPronta` low for 3 cycles in ACESSO_LER: the instruction takes 8 cycles, `IouD`=1 during all 4 ACESSO_LER cycles and `RegFonte`=1 in ESCREVE_MEM.
- `ESPERA_MAX`=15 with `MemPronta` held low in BUSCA: `Erro` rises and the state is ERRO after 16 cycles. `MemPronta`=1 on the 16th cycle instead gives DECOD and no error.
- Opcode 111: sequence BUSCA, DECOD, PARADO. The state then holds for 100 cycles with all enables 0, and `Retiradas`=1.
- Opcode 011 followed by 101: `Beqz` is high for 1 cycle in DESVIO, then `Ji` and `EscPC` are high together for 1 cycle in SALTO, and `Retiradas`=2.
- `Resetn` pulsed low during ACESSO_ESC: `EscMem` drops within the same cycle, `Retiradas`=0, and the state is BUSCA after release.
